// File: rtl/s_cycle_cpu_pkg.sv
// Shared decode constants, ALU operation encoding and the R-type field layout
// used by the single-cycle core.
package s_cycle_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADDU,
        ALU_SUBU,
        ALU_ADD,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } dec_t;

    // Unsupported encodings come back with valid=0 so the write is simply skipped.
    function automatic dec_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.valid = 1'b0;
        d.op    = ALU_ADDU;
        if (opcode == OP_RTYPE) begin
            d.valid = 1'b1;
            case (funct)
                FN_ADDU: d.op = ALU_ADDU;
                FN_SUBU: d.op = ALU_SUBU;
                FN_ADD:  d.op = ALU_ADD;
                FN_AND:  d.op = ALU_AND;
                FN_OR:   d.op = ALU_OR;
                FN_SLT:  d.op = ALU_SLT;
                default: d.valid = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/s_cycle_cpu_alu.sv
// Combinational 32-bit ALU; overflow is only raised for the trapping signed add.
module s_cycle_cpu_alu
    import s_cycle_cpu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    always_comb begin
        sum      = a + b;
        diff     = a - b;
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADDU: result = sum;
            ALU_SUBU: result = diff;
            ALU_ADD: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/s_cycle_cpu_gpr.sv
// 32x32 register file: two combinational reads, one synchronous write, $0 hardwired to zero.
module s_cycle_cpu_gpr (
    input  logic        clock,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] gp_registers [0:31];

    // No reset here: preloaded contents must survive a core reset.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr != 5'd0)) begin
            gp_registers[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : gp_registers[rd_addr_a];
        rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : gp_registers[rd_addr_b];
    end

endmodule

// File: rtl/s_cycle_cpu_im.sv
// Instruction memory: combinational word read, plus a synchronous load port
// that the core ties off (contents normally arrive by hierarchical preload).
module s_cycle_cpu_im #(
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] ins_memory [0:2**AW-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            ins_memory[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = ins_memory[rd_addr];
    end

endmodule

// File: rtl/s_cycle_cpu.sv
// Single-cycle MIPS R-type core: fetch, decode, execute and write back in one clock.
module s_cycle_cpu
    import s_cycle_cpu_pkg::*;
#(
    parameter int IM_ADDR_WIDTH = 8
) (
    input logic clock,
    input logic reset
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_word;
    rtype_t      instr;
    dec_t        dec;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_result;
    logic        alu_ovf;
    logic        gpr_wr_en;
    logic [4:0]  unused_shamt;

    s_cycle_cpu_im #(.AW(IM_ADDR_WIDTH)) IM (
        .clock   (clock),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data (32'd0),
        .rd_addr (pc_q[IM_ADDR_WIDTH+1:2]),
        .rd_data (instr_word)
    );

    s_cycle_cpu_gpr GPR (
        .clock     (clock),
        .rd_addr_a (instr.rs),
        .rd_addr_b (instr.rt),
        .rd_data_a (rs_val),
        .rd_data_b (rt_val),
        .wr_en     (gpr_wr_en),
        .wr_addr   (instr.rd),
        .wr_data   (alu_result)
    );

    s_cycle_cpu_alu ALU (
        .op       (dec.op),
        .a        (rs_val),
        .b        (rt_val),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    always_comb begin
        instr        = rtype_t'(instr_word);
        unused_shamt = instr.shamt;
        dec          = decode_instr(instr.opcode, instr.funct);
        pc_d         = pc_q + 32'd4;
        // Reset low drops the retiring write so register contents are untouched.
        gpr_wr_en    = reset && dec.valid && !alu_ovf;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_s_cycle_cpu.sv
// Self-checking bench for s_cycle_cpu: directed tables, corner sequences and a
// randomized program compared against an instruction-level reference model.
module tb_s_cycle_cpu;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    s_cycle_cpu #(.IM_ADDR_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] old;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [31:0] instr;
        int          rd;
        logic [31:0] exp;
    } prog_vec_t;

    alu_vec_t    av [13];
    prog_vec_t   pv [9];
    logic [31:0] m_regs [32];
    logic [31:0] m_im [256];
    int unsigned m_pc;

    function automatic logic [31:0] enc(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_im();
        for (int i = 0; i < 256; i++) dut.IM.ins_memory[i] = 32'd0;
    endtask

    task automatic reset_cycle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Reference: executes one instruction from the bench's own memory image.
    task automatic model_exec();
        logic [31:0] ins, a, b, r;
        logic        wr;
        longint      s;
        int          rd;
        ins  = m_im[(m_pc >> 2) % 256];
        m_pc = m_pc + 4;
        a    = (ins[25:21] == 0) ? 32'd0 : m_regs[ins[25:21]];
        b    = (ins[20:16] == 0) ? 32'd0 : m_regs[ins[20:16]];
        rd   = int'(ins[15:11]);
        wr   = (ins[31:26] == 6'h00);
        r    = 32'd0;
        case (ins[5:0])
            6'h21: r = a + b;
            6'h23: r = a - b;
            6'h20: begin
                s = longint'($signed(a)) + longint'($signed(b));
                if (s > 64'sd2147483647 || s < -64'sd2147483648) wr = 1'b0;
                r = a + b;
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: wr = 1'b0;
        endcase
        if (wr && rd != 0) m_regs[rd] = r;
    endtask

    initial begin
        reset = 1'b0;

        av[0]  = '{enc(1,2,3,6'h20), 32'h7FFF_FFFF, 32'h0000_0001, 32'h55, 32'h55};
        av[1]  = '{enc(1,2,3,6'h20), 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h55, 32'h7FFF_FFFE};
        av[2]  = '{enc(1,2,3,6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 32'h55, 32'h1};
        av[3]  = '{enc(1,2,3,6'h2A), 32'h0000_0001, 32'hFFFF_FFFF, 32'h55, 32'h0};
        av[4]  = '{enc(1,2,3,6'h21), 32'hFFFF_FFFF, 32'h0000_0002, 32'h55, 32'h1};
        av[5]  = '{enc(1,2,3,6'h23), 32'h0000_0000, 32'h0000_0001, 32'h55, 32'hFFFF_FFFF};
        av[6]  = '{enc(1,2,3,6'h20), 32'h8000_0000, 32'hFFFF_FFFF, 32'hAA, 32'hAA};
        av[7]  = '{enc(1,2,3,6'h24), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h55, 32'h00F0_1200};
        av[8]  = '{enc(1,2,3,6'h25), 32'hF0F0_0000, 32'h0000_0F0F, 32'h55, 32'hF0F0_0F0F};
        av[9]  = '{enc(1,2,3,6'h22), 32'h9, 32'h4, 32'h77, 32'h77};
        av[10] = '{32'h2022_1821, 32'h1, 32'h2, 32'h33, 32'h33};
        av[11] = '{enc(1,2,3,6'h2A), 32'h5, 32'h5, 32'h99, 32'h0};
        av[12] = '{enc(1,2,3,6'h20), 32'h3, 32'h4, 32'h99, 32'h7};

        pv[0] = '{32'h0022_5821, 11, 32'd3};
        pv[1] = '{32'h0163_5823, 11, 32'd0};
        pv[2] = '{32'h0164_A821, 21, 32'd4};
        pv[3] = '{enc(5,6,11,6'h2A), 11, 32'd1};
        pv[4] = '{enc(6,5,12,6'h2A), 12, 32'd0};
        pv[5] = '{enc(11,12,21,6'h23), 21, 32'd1};
        pv[6] = '{enc(7,8,11,6'h24), 11, 32'd0};
        pv[7] = '{enc(9,10,21,6'h24), 21, 32'd8};
        pv[8] = '{enc(11,12,21,6'h25), 21, 32'd0};

        // Reset inhibits the write even while the fetched word is valid.
        clear_im();
        dut.IM.ins_memory[0] = enc(1,2,3,6'h21);
        for (int i = 0; i < 32; i++) dut.GPR.gp_registers[i] = 32'd0;
        dut.GPR.gp_registers[1] = 32'd10;
        dut.GPR.gp_registers[2] = 32'd20;
        dut.GPR.gp_registers[3] = 32'hC0DE;
        step();
        step();
        check("reset_no_write", dut.GPR.gp_registers[3], 32'hC0DE);
        reset = 1'b1;
        step();
        check("first_after_reset", dut.GPR.gp_registers[3], 32'd30);

        // Single-instruction ALU vectors.
        for (int v = 0; v < 13; v++) begin
            clear_im();
            dut.IM.ins_memory[0] = av[v].instr;
            reset_cycle();
            dut.GPR.gp_registers[1] = av[v].a;
            dut.GPR.gp_registers[2] = av[v].b;
            dut.GPR.gp_registers[3] = av[v].old;
            step();
            check($sformatf("alu_vec%0d", v), dut.GPR.gp_registers[3], av[v].exp);
        end

        // Nine-instruction dependent program.
        clear_im();
        for (int i = 0; i < 9; i++) dut.IM.ins_memory[i] = pv[i].instr;
        reset_cycle();
        for (int i = 1; i <= 10; i++) dut.GPR.gp_registers[i] = i;
        dut.GPR.gp_registers[22] = 32'hDEAD_0022;
        dut.GPR.gp_registers[23] = 32'hDEAD_0023;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("prog%0d_r%0d", i, pv[i].rd), dut.GPR.gp_registers[pv[i].rd], pv[i].exp);
        end
        check("prog_r22_untouched", dut.GPR.gp_registers[22], 32'hDEAD_0022);
        check("prog_r23_untouched", dut.GPR.gp_registers[23], 32'hDEAD_0023);

        // Writes to $0 are discarded and $0 reads as zero.
        clear_im();
        dut.IM.ins_memory[0] = enc(1,2,0,6'h21);
        dut.IM.ins_memory[1] = enc(0,1,3,6'h21);
        reset_cycle();
        dut.GPR.gp_registers[0] = 32'd0;
        dut.GPR.gp_registers[1] = 32'd5;
        dut.GPR.gp_registers[2] = 32'd6;
        dut.GPR.gp_registers[3] = 32'hFF;
        step();
        check("r0_write_dropped", dut.GPR.gp_registers[0], 32'd0);
        step();
        check("r0_reads_zero", dut.GPR.gp_registers[3], 32'd5);

        // Reset mid-program drops the retiring write and restarts at word 0.
        clear_im();
        dut.IM.ins_memory[0] = enc(11,1,11,6'h21);
        dut.IM.ins_memory[1] = enc(12,1,12,6'h21);
        dut.IM.ins_memory[2] = enc(13,1,13,6'h21);
        dut.IM.ins_memory[3] = enc(14,1,14,6'h21);
        reset_cycle();
        dut.GPR.gp_registers[1] = 32'd1;
        for (int i = 11; i <= 14; i++) dut.GPR.gp_registers[i] = 32'd0;
        step();
        step();
        step();
        check("mid_r13_before", dut.GPR.gp_registers[13], 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_r14_dropped", dut.GPR.gp_registers[14], 32'd0);
        check("mid_r11_kept", dut.GPR.gp_registers[11], 32'd1);
        step();
        check("mid_restart_r11", dut.GPR.gp_registers[11], 32'd2);
        check("mid_restart_r12", dut.GPR.gp_registers[12], 32'd1);
        step();
        check("mid_restart_r12b", dut.GPR.gp_registers[12], 32'd2);

        // Randomized program against the reference model, including memory wrap.
        for (int i = 0; i < 256; i++) begin
            logic [5:0]  op, fn;
            logic [31:0] w;
            int          sel;
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h00;
            sel = $urandom_range(0, 6);
            case (sel)
                0: fn = 6'h21;
                1: fn = 6'h23;
                2: fn = 6'h20;
                3: fn = 6'h24;
                4: fn = 6'h25;
                5: fn = 6'h2A;
                default: fn = 6'($urandom);
            endcase
            w = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom), fn};
            m_im[i] = w;
            dut.IM.ins_memory[i] = w;
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 5))
                0: v = 32'h7FFF_FFFF;
                1: v = 32'h8000_0000;
                2: v = 32'hFFFF_FFFF;
                3: v = 32'd1;
                default: v = $urandom;
            endcase
            if (i == 0) v = 32'd0;
            m_regs[i] = v;
            dut.GPR.gp_registers[i] = v;
        end
        reset_cycle();
        m_pc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 100) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                m_pc = 0;
            end else begin
                step();
                model_exec();
            end
            for (int r = 0; r < 32; r++) begin
                check($sformatf("rand_c%0d_r%0d", cyc, r), dut.GPR.gp_registers[r], m_regs[r]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_cycle_cpu.md
# s_cycle_cpu

Single-cycle 32-bit MIPS-subset processor core. Executes one R-type ALU instruction per clock (addu, subu, add, and, or, slt) from an internal instruction memory and writes results to a 32×32 general-purpose register file. Top-level leaf of the processor design. It has no external data ports; benches preload instructions and registers hierarchically and observe register contents hierarchically.

## Interface
- IM_ADDR_WIDTH, 8: word-address width of instruction memory (256 words).
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset; one clock, synchronous, active-low (reset=0 resets on the rising edge).

## Operation
- Required hierarchy, relied on by benches:
  - Instruction memory instance `IM` with array `ins_memory[0:2**IM_ADDR_WIDTH-1]` of 32-bit words.
  - Register file instance `GPR` with array `gp_registers[0:31]` of 32-bit words.
  - Neither array has an initializer.
- PC: 32-bit, byte address.
  - Instruction fetched combinationally as `IM.ins_memory[PC[IM_ADDR_WIDTH+1:2]]`.
  - Next PC = PC+4, wrapping naturally at 2^32.
  - Memory index wraps modulo depth.
- Decode: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- Supported, all with opcode 0x00; each writes rd:
  - addu 0x21: rs+rt, modulo 2^32.
  - subu 0x23: rs−rt, modulo 2^32.
  - add 0x20: rs+rt, signed. On signed overflow the write is suppressed.
  - and 0x24: bitwise and.
  - or 0x25: bitwise or.
  - slt 0x2A: 1 if signed rs < signed rt, else 0 (zero-extended to 32 bits).
- Any other opcode/funct: no register write; PC still advances.
- Register file:
  - Two combinational read ports and one synchronous write port.
  - Writes to rd=0 are discarded; reads of $0 return 0.
  - A read of a register being written in the same cycle returns the old value.
- Reset:
  - Sets PC to 0x0000_0000 and inhibits the register write in that cycle.
  - Does NOT clear `gp_registers` or `ins_memory`, so hierarchical preloads survive reset.

## Timing
- One instruction per clock.
- Result is visible in `gp_registers` immediately after the rising edge that retires the instruction.
- Edge with reset=0: PC←0, no write.
- First edge with reset=1: executes `ins_memory[0]`, writes its result, PC←4.
- Reset asserted mid-program: at the next edge the current instruction's write is dropped and PC←0. Execution restarts at word 0 on the first edge after release.
- Back-to-back dependencies need no stalls. Each instruction reads values written on prior edges.

## Structure
- Shared package `s_cycle_cpu_pkg`:
  - Opcode constant OP_RTYPE.
  - Funct constants FN_ADDU, FN_SUBU, FN_ADD, FN_AND, FN_OR, FN_SLT.
  - ALU-operation enum.
- Sub-modules and instance names:
  - `IM`: instruction memory.
  - `GPR`: register file.
  - `ALU`: combinational, with an overflow output. This is the natural separable block.
  - Controller and PC register are internal logic, or optional small sub-modules.

## Test plan
- Preload $1..$10 = 1..10. Run addu $11,$1,$2; subu $11,$11,$3; addu $21,$11,$4 (words 0x00225821, 0x01635823, 0x0164A821) → $11=3, then $11=0, then $21=4.
- slt $11,$5,$6 and slt $12,$6,$5, then subu $21,$11,$12 → $11=1, $12=0, $21=1.
- and $11,$7,$8 → $11=0; and $21,$9,$10 → $21=8; or $21,$11,$12 → $21=0. After the nine-instruction program $22 and $23 remain unwritten.
- add with $1=0x7FFF_FFFF, $2=1 into $3 (old value 0x55) → $3 stays 0x55. With $2=0xFFFF_FFFF (−1) → $3=0x7FFF_FFFE. slt with $1=0xFFFF_FFFF, $2=1 → 1 (signed compare).
- Write to $0 (addu $0,$1,$2) → $0 reads 0. A following addu $3,$0,$1 gives $3=$1.
- Assert reset=0 for one edge after the 3rd instruction → that edge's write is dropped, registers keep their values, and execution resumes from word 0.
